des_sbox_pipe: RTL and testbench
================================

Name: des_sbox_pipe

Overview:
- Pipelined, multi-lane DES Feistel substitution stage.
- Each lane takes one 48-bit post-key-mix word, applies S1..S8 in parallel, and returns 32 bits.
- Uses a valid/ready handshake with full backpressure.
- Sits between the key-XOR stage and the round combiner, replacing standalone per-S-box instances in the round datapath.

Parameters:
- LANES, 1: number of independent 48-bit words processed per transfer (1..8).
- OUT_REG, 1: 0 gives latency 1 (lookup register only); 1 adds an output register, giving latency 2.

Ports:
- wClk  input  1  rising-edge clock.
- wRstN  input  1  asynchronous active-low reset.
- wInValid  input  1  input word(s) valid.
- wInReady  output  1  stage can accept this cycle.
- wInputData  input  [0:48*LANES-1]  lane L occupies bits 48L..48L+47, DES numbering (bit 0 = MSB).
- wOutValid  output  1  output word(s) valid.
- wOutReady  input  1  downstream accepts.
- wOutputData  output  [0:32*LANES-1]  lane L occupies bits 32L..32L+31.
- wXferCount  output  16  count of completed output transfers; wraps at 16'hFFFF -> 0.

Behaviour:
- Substitution, per lane:
  - Chunk k (bits 6k..6k+5, k=0..7) feeds S(k+1).
  - Row = {b0,b5}; column = {b1,b2,b3,b4}.
  - 4-bit result goes to output bits 4k..4k+3.
  - Standard FIPS 46-3 tables; no X outputs for any input.
- Pipeline:
  - 1+OUT_REG register stages. Each stage has its own valid bit and data register.
  - A stage advances when its next stage is empty or is advancing; the last stage advances when wOutReady=1.
  - wInReady = !v0 | advance0, combinational from downstream state. Full throughput, one transfer/cycle, with no bubble under continuous ready.
  - Input transfer: wInValid & wInReady. Output transfer: wOutValid & wOutReady.
- Stall: while wOutValid=1 & wOutReady=0, wOutputData and wOutValid are held stable. No data is dropped or duplicated.
- Simultaneous accept and emit in a full pipeline is allowed; occupancy is unchanged.
- wInputData is ignored when wInValid=0. Data registers load only on transfer, so there is no toggle on idle.
- Reset (asynchronous assert, synchronous-safe deassert by upstream):
  - All valid bits = 0, so wOutValid = 0.
  - wOutputData = 0.
  - wXferCount = 0.
  - wInReady = 1 in the first cycle after deassert.
  - Reset mid-stream discards all in-flight words.
- wXferCount increments by 1 on each output transfer, regardless of LANES.
- Latency, input transfer to wOutValid: OUT_REG=0 gives 1 cycle; OUT_REG=1 gives 2 cycles.

Optional Feature:
- Macro DES_SBOX_PPERM_EN.
- Defined: each lane's 32-bit S-box result passes through the DES P permutation (16 7 20 21 29 12 28 17 1 15 23 26 5 18 31 10 2 8 24 14 32 27 3 9 19 13 30 6 22 11 4 25, 1-based) before the first register. Latency is unchanged.
- Undefined: raw S1..S8 concatenation is output and the P permutation is performed downstream.

Test Plan:
- Zero vector: LANES=1, OUT_REG=1, wOutReady=1, input 48'h000000000000 -> wOutValid exactly 2 cycles later. Output 32'hEFA72C4D without the macro; with DES_SBOX_PPERM_EN, the P-permuted value of EFA72C4D.
- All-ones vector: input 48'hFFFFFFFFFFFF -> 32'hD9CE3DCB without the macro.
- Known-answer vector: input 48'h6117BA866527 -> 32'h5C82B597 without the macro; 32'h234AA9BB with DES_SBOX_PPERM_EN.
- Multi-lane backpressure: LANES=2, lane0 = 6117BA866527, lane1 = 000000000000.
  - Stream 4 words with wOutReady held low for cycles 3..6.
  - Expect wInReady=0 once both stages are full, and output held stable.
  - All 4 words emerge in order with no loss.
  - wXferCount=4.
- Throughput: OUT_REG=0, 100 back-to-back words with wOutReady=1 -> 100 outputs in 100 consecutive cycles after 1-cycle latency, wXferCount=100.
- Reset mid-operation: assert wRstN=0 with 2 words in flight -> wOutValid=0, wOutputData=0, wXferCount=0 immediately (async). After release, the next input produces correct output and no stale word appears.

Source files
------------

// File: rtl/des_sbox_pipe.sv
// Pipelined multi-lane DES S-box stage (S1..S8) with valid/ready backpressure.
// Define DES_SBOX_PPERM_EN to fold the DES P permutation in ahead of the first register.
module des_sbox_pipe #(
    parameter int LANES   = 1,
    parameter int OUT_REG = 1
) (
    input  logic                  wClk,
    input  logic                  wRstN,
    input  logic                  wInValid,
    output logic                  wInReady,
    input  logic [0:48*LANES-1]   wInputData,
    output logic                  wOutValid,
    input  logic                  wOutReady,
    output logic [0:32*LANES-1]   wOutputData,
    output logic [15:0]           wXferCount
);

    // Each entry is one S-box, 64 nibbles in row-major order (row*16 + col), first nibble in the MSBs.
    localparam logic [255:0] SBOX_TBL [8] = '{
        256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
        256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
        256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
        256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
        256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
        256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
        256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
        256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
    };

    function automatic logic [3:0] sbox_lu(input logic [2:0] k, input logic [5:0] c);
        logic [255:0] t;
        logic [7:0]   sh;
        t  = SBOX_TBL[k];
        // c[5] is DES bit 0: row = {b0,b5}, column = b1..b4
        sh = 8'd252 - {c[5], c[0], c[4:1], 2'b00};
        return t[sh +: 4];
    endfunction

    logic [0:32*LANES-1] w_sub;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic [47:0] w_x;
            logic [31:0] w_s;
            assign w_x = wInputData[48*gi +: 48];
            for (genvar gk = 0; gk < 8; gk++) begin : g_box
                assign w_s[31-4*gk -: 4] = sbox_lu(3'(gk), w_x[47-6*gk -: 6]);
            end
`ifdef DES_SBOX_PPERM_EN
            localparam int P_TBL [32] = '{16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
                                          2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};
            logic [31:0] w_p;
            for (genvar gp = 0; gp < 32; gp++) begin : g_perm
                assign w_p[31-gp] = w_s[32-P_TBL[gp]];
            end
            assign w_sub[32*gi +: 32] = w_p;
`else
            assign w_sub[32*gi +: 32] = w_s;
`endif
        end
    endgenerate

    logic                r_v0;
    logic [0:32*LANES-1] r_d0;
    logic                w_acc1;
    logic [15:0]         r_cnt;

    assign wInReady   = !r_v0 || w_acc1;
    assign wXferCount = r_cnt;

    always_ff @(posedge wClk or negedge wRstN) begin
        if (!wRstN) begin
            r_v0 <= 1'b0;
            r_d0 <= '0;
        end else if (wInReady) begin
            r_v0 <= wInValid;
            if (wInValid) r_d0 <= w_sub;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_oreg
            logic                r_v1;
            logic [0:32*LANES-1] r_d1;
            assign w_acc1      = !r_v1 || wOutReady;
            assign wOutValid   = r_v1;
            assign wOutputData = r_d1;
            always_ff @(posedge wClk or negedge wRstN) begin
                if (!wRstN) begin
                    r_v1 <= 1'b0;
                    r_d1 <= '0;
                end else if (w_acc1) begin
                    r_v1 <= r_v0;
                    if (r_v0) r_d1 <= r_d0;
                end
            end
        end else begin : g_noreg
            assign w_acc1      = wOutReady;
            assign wOutValid   = r_v0;
            assign wOutputData = r_d0;
        end
    endgenerate

    always_ff @(posedge wClk or negedge wRstN) begin
        if (!wRstN) begin
            r_cnt <= 16'd0;
        end else if (wOutValid && wOutReady) begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_des_sbox_pipe.sv
// Bench for des_sbox_pipe: a 2-lane/2-stage and a 1-lane/1-stage instance checked each cycle
// against a queue-based reference built from the S-box tables.
module tb_des_sbox_pipe;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        a_iv, a_ir, a_ov, a_or;
    logic [0:95] a_id;
    logic [0:63] a_od;
    logic [15:0] a_cnt;
    logic        b_iv, b_ir, b_ov, b_or;
    logic [0:47] b_id;
    logic [0:31] b_od;
    logic [15:0] b_cnt;

    des_sbox_pipe #(.LANES(2), .OUT_REG(1)) u_a (
        .wClk(clk), .wRstN(rst_n), .wInValid(a_iv), .wInReady(a_ir), .wInputData(a_id),
        .wOutValid(a_ov), .wOutReady(a_or), .wOutputData(a_od), .wXferCount(a_cnt));

    des_sbox_pipe #(.LANES(1), .OUT_REG(0)) u_b (
        .wClk(clk), .wRstN(rst_n), .wInValid(b_iv), .wInReady(b_ir), .wInputData(b_id),
        .wOutValid(b_ov), .wOutReady(b_or), .wOutputData(b_od), .wXferCount(b_cnt));

    localparam int S_TBL [8][64] = '{
        '{14,4,13,1,2,15,11,8,3,10,6,12,5,9,0,7, 0,15,7,4,14,2,13,1,10,6,12,11,9,5,3,8,
          4,1,14,8,13,6,2,11,15,12,9,7,3,10,5,0, 15,12,8,2,4,9,1,7,5,11,3,14,10,0,6,13},
        '{15,1,8,14,6,11,3,4,9,7,2,13,12,0,5,10, 3,13,4,7,15,2,8,14,12,0,1,10,6,9,11,5,
          0,14,7,11,10,4,13,1,5,8,12,6,9,3,2,15, 13,8,10,1,3,15,4,2,11,6,7,12,0,5,14,9},
        '{10,0,9,14,6,3,15,5,1,13,12,7,11,4,2,8, 13,7,0,9,3,4,6,10,2,8,5,14,12,11,15,1,
          13,6,4,9,8,15,3,0,11,1,2,12,5,10,14,7, 1,10,13,0,6,9,8,7,4,15,14,3,11,5,2,12},
        '{7,13,14,3,0,6,9,10,1,2,8,5,11,12,4,15, 13,8,11,5,6,15,0,3,4,7,2,12,1,10,14,9,
          10,6,9,0,12,11,7,13,15,1,3,14,5,2,8,4, 3,15,0,6,10,1,13,8,9,4,5,11,12,7,2,14},
        '{2,12,4,1,7,10,11,6,8,5,3,15,13,0,14,9, 14,11,2,12,4,7,13,1,5,0,15,10,3,9,8,6,
          4,2,1,11,10,13,7,8,15,9,12,5,6,3,0,14, 11,8,12,7,1,14,2,13,6,15,0,9,10,4,5,3},
        '{12,1,10,15,9,2,6,8,0,13,3,4,14,7,5,11, 10,15,4,2,7,12,9,5,6,1,13,14,0,11,3,8,
          9,14,15,5,2,8,12,3,7,0,4,10,1,13,11,6, 4,3,2,12,9,5,15,10,11,14,1,7,6,0,8,13},
        '{4,11,2,14,15,0,8,13,3,12,9,7,5,10,6,1, 13,0,11,7,4,9,1,10,14,3,5,12,2,15,8,6,
          1,4,11,13,12,3,7,14,10,15,6,8,0,5,9,2, 6,11,13,8,1,4,10,7,9,5,0,15,14,2,3,12},
        '{13,2,8,4,6,15,11,1,10,9,3,14,5,0,12,7, 1,15,13,8,10,3,7,4,12,5,6,11,0,14,9,2,
          7,11,4,1,9,12,14,2,0,6,10,13,15,3,5,8, 2,1,14,7,4,10,8,13,15,12,9,0,3,5,6,11}
    };

`ifdef DES_SBOX_PPERM_EN
    localparam int P_TBL [32] = '{16,7,20,21,29,12,28,17,1,15,23,26,5,18,31,10,
                                  2,8,24,14,32,27,3,9,19,13,30,6,22,11,4,25};
    localparam logic [31:0] KAT_6117 = 32'h234AA9BB;
`else
    localparam logic [31:0] KAT_6117 = 32'h5C82B597;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [63:0] d;
        int          rdy;
    } ent_t;
    ent_t        qa[$];
    ent_t        qb[$];
    logic [15:0] ca_m = 16'd0;
    logic [15:0] cb_m = 16'd0;
    logic        fa_in, fa_out, fb_in, fb_out, la_ir;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_f(input logic [47:0] x);
        logic [31:0] r;
        int six, row, col;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            six = int'(x[47-6*k -: 6]);
            row = (six >> 5) * 2 + (six & 1);
            col = (six >> 1) & 15;
            r = (r << 4) | 32'(S_TBL[k][row*16 + col]);
        end
`ifdef DES_SBOX_PPERM_EN
        begin
            logic [31:0] p;
            for (int i = 0; i < 32; i++) p[31-i] = r[32-P_TBL[i]];
            r = p;
        end
`endif
        return r;
    endfunction

    function automatic logic [63:0] ref_a(input logic [0:95] x);
        logic [47:0] l0, l1;
        l0 = x[0:47];
        l1 = x[48:95];
        return {ref_f(l0), ref_f(l1)};
    endfunction

    // One clock cycle: check outputs against the model, then apply the transfers at the edge.
    task automatic tick();
        logic ea_v, ea_r, eb_v, eb_r;
        #1;
        ea_v = (qa.size() > 0) && (qa[0].rdy <= cyc);
        ea_r = (qa.size() < 2) || a_or;
        eb_v = (qb.size() > 0) && (qb[0].rdy <= cyc);
        eb_r = (qb.size() < 1) || b_or;
        la_ir = a_ir;
        chk("a_in_ready", 64'(a_ir), 64'(ea_r));
        chk("a_out_valid", 64'(a_ov), 64'(ea_v));
        chk("a_count", 64'(a_cnt), 64'(ca_m));
        if (ea_v) chk("a_data", a_od, qa[0].d);
        chk("b_in_ready", 64'(b_ir), 64'(eb_r));
        chk("b_out_valid", 64'(b_ov), 64'(eb_v));
        chk("b_count", 64'(b_cnt), 64'(cb_m));
        if (eb_v) chk("b_data", 64'(b_od), qb[0].d);
        fa_in  = a_iv && ea_r;
        fa_out = ea_v && a_or;
        fb_in  = b_iv && eb_r;
        fb_out = eb_v && b_or;
        @(posedge clk);
        cyc++;
        if (fa_out) begin void'(qa.pop_front()); ca_m++; end
        if (fa_in) qa.push_back('{d: ref_a(a_id), rdy: cyc + 1});
        if (fb_out) begin void'(qb.pop_front()); cb_m++; end
        if (fb_in) qb.push_back('{d: {32'h0, ref_f(b_id)}, rdy: cyc});
        @(negedge clk);
    endtask

    initial begin
        int w, n, first, last;
        logic [15:0] base;
        logic saw_block;
        a_iv = 0; a_or = 0; a_id = '0;
        b_iv = 0; b_or = 0; b_id = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_a_valid", 64'(a_ov), 64'd0);
        chk("rst_a_data", a_od, 64'd0);
        chk("rst_a_count", 64'(a_cnt), 64'd0);
        chk("rst_b_valid", 64'(b_ov), 64'd0);
        chk("rst_b_data", 64'(b_od), 64'd0);
        chk("rst_b_count", 64'(b_cnt), 64'd0);
        @(negedge clk);
        rst_n = 1;

        // Known-answer vectors
        a_or = 1; b_or = 1;
        a_iv = 1; a_id = {48'h000000000000, 48'hFFFFFFFFFFFF};
        b_iv = 1; b_id = 48'h000000000000;
        tick();
`ifndef DES_SBOX_PPERM_EN
        chk("kat_zero_b", 64'(b_od), 64'h00000000EFA72C4D);
`endif
        a_id = {48'h6117BA866527, 48'h000000000000};
        b_id = 48'hFFFFFFFFFFFF;
        tick();
`ifndef DES_SBOX_PPERM_EN
        chk("kat_ones_b", 64'(b_od), 64'h00000000D9CE3DCB);
        chk("kat_zero_ones_a", a_od, 64'hEFA72C4DD9CE3DCB);
`endif
        a_iv = 0;
        b_id = 48'h6117BA866527;
        tick();
        chk("kat_6117_b", 64'(b_od), 64'(KAT_6117));
        chk("kat_6117_a", 64'(a_od[0:31]), 64'(KAT_6117));
        b_iv = 0;
        repeat (3) tick();

        // Two-lane backpressure: downstream stalls for cycles 3..6
        base = ca_m; w = 0; saw_block = 0;
        for (int i = 0; i < 40 && (w < 4 || qa.size() > 0); i++) begin
            a_iv = (w < 4);
            a_id = {48'h6117BA866527, 48'(w)};
            a_or = !(i >= 3 && i <= 6);
            tick();
            if (a_iv && !la_ir) saw_block = 1;
            if (fa_in) w++;
        end
        a_iv = 0; a_or = 1;
        chk("bp_stall_seen", 64'(saw_block), 64'd1);
        chk("bp_all_out", 64'(qa.size()), 64'd0);
        chk("bp_count", 64'(a_cnt), 64'(base + 16'd4));

        // Throughput: 100 back-to-back words through the single-stage instance
        base = cb_m; n = 0; first = -1; last = -1; b_or = 1;
        for (int i = 0; i < 102; i++) begin
            b_iv = (i < 100);
            b_id = 48'({$urandom, $urandom});
            tick();
            if (fb_out) begin
                n++;
                if (first < 0) first = cyc;
                last = cyc;
            end
        end
        b_iv = 0;
        chk("tp_outs", 64'(n), 64'd100);
        chk("tp_span", 64'(last - first + 1), 64'd100);
        chk("tp_count", 64'(b_cnt), 64'(base + 16'd100));

        // Random traffic on both instances
        for (int i = 0; i < 300; i++) begin
            a_iv = ($urandom % 4) != 0;
            a_or = ($urandom % 3) != 0;
            a_id = {$urandom, $urandom, $urandom};
            b_iv = ($urandom % 4) != 0;
            b_or = ($urandom % 3) != 0;
            b_id = 48'({$urandom, $urandom});
            tick();
        end
        a_iv = 0; b_iv = 0; a_or = 1; b_or = 1;
        repeat (3) tick();

        // Reset with words in flight
        a_or = 0; b_or = 0; a_iv = 1; b_iv = 1;
        a_id = {$urandom, $urandom, $urandom};
        b_id = 48'({$urandom, $urandom});
        tick();
        a_id = {$urandom, $urandom, $urandom};
        tick();
        chk("pre_rst_a_valid", 64'(a_ov), 64'd1);
        a_iv = 0; b_iv = 0;
        #2 rst_n = 0;
        #1;
        chk("mid_rst_a_valid", 64'(a_ov), 64'd0);
        chk("mid_rst_a_data", a_od, 64'd0);
        chk("mid_rst_a_count", 64'(a_cnt), 64'd0);
        chk("mid_rst_b_valid", 64'(b_ov), 64'd0);
        chk("mid_rst_b_data", 64'(b_od), 64'd0);
        chk("mid_rst_b_count", 64'(b_cnt), 64'd0);
        qa.delete(); qb.delete(); ca_m = 16'd0; cb_m = 16'd0;
        @(negedge clk);
        rst_n = 1;
        a_or = 1; b_or = 1;
        a_iv = 1; a_id = {48'h000000000000, 48'h6117BA866527};
        b_iv = 1; b_id = 48'h6117BA866527;
        tick();
        a_iv = 0; b_iv = 0;
        chk("post_rst_b", 64'(b_od), 64'(KAT_6117));
        tick();
        chk("post_rst_a_lane1", 64'(a_od[32:63]), 64'(KAT_6117));
        repeat (3) tick();
        chk("post_rst_a_count", 64'(a_cnt), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
